wb_arbiter: RTL and testbench

- Round-robin Wishbone bus arbiter that lets NM wbmaster instances share one slave port.
- Grants ownership per bus cycle, i.e. for as long as the owner holds CYC.
- Muxes the owner's address, data, select and strobe signals to the slave.
- Routes ACK/ERR back to the owner only; sits between the master array and the single slave/interconnect.

---
 rtl/wb_arbiter_pkg.sv | 14 +
 rtl/wb_rr_pick.sv | 31 +++
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared widths, master count default and FSM encoding for the Wishbone round-robin arbiter.
package wb_arbiter_pkg;

  localparam int unsigned ADDRESS_WIDTH = 32;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned SELECT_WIDTH  = 4;
  localparam int unsigned WB_ARB_NM     = 2;

  typedef enum logic {
    WB_ARB_IDLE  = 1'b0,
    WB_ARB_OWNED = 1'b1
  } wb_arb_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module wb_rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 2) ? 2 : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [PW:0]   idx;
  logic [PW-1:0] sel;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    sel   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (PW+1)'(ptr) + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      sel = PW'(idx);
      if (!valid && req[sel]) begin
        gnt[sel] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave, ownership held per CYC.
// Optional watchdog that errors out a stalled owner: define WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NM = WB_ARB_NM,
  parameter int unsigned AW = ADDRESS_WIDTH,
  parameter int unsigned DW = DATA_WIDTH,
  parameter int unsigned SW = SELECT_WIDTH
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  input  logic [NM-1:0]    M_CYC_I,
  input  logic [NM-1:0]    M_STB_I,
  input  logic [NM-1:0]    M_WE_I,
  input  logic [NM*AW-1:0] M_ADR_I,
  input  logic [NM*DW-1:0] M_DAT_I,
  input  logic [NM*SW-1:0] M_SEL_I,
  output logic [NM-1:0]    M_ACK_O,
  output logic [NM-1:0]    M_ERR_O,
  output logic [DW-1:0]    M_DAT_O,
  output logic           S_CYC_O,
  output logic           S_STB_O,
  output logic           S_WE_O,
  output logic [AW-1:0]  S_ADR_O,
  output logic [DW-1:0]  S_DAT_O,
  output logic [SW-1:0]  S_SEL_O,
  input  logic [DW-1:0]  S_DAT_I,
  input  logic           S_ACK_I,
  input  logic           S_ERR_I,
  output logic [NM-1:0]  GNT_O
);

  localparam int unsigned PW = (NM > 2) ? 2 : 1;

  wb_arb_state_e state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner_idx;
  logic [PW-1:0] next_ptr;
  logic [NM-1:0] req;
  logic [NM-1:0] pick_gnt;
  logic          pick_valid;
  logic          owner_cyc;
  logic          to_hit;
  logic          release_bus;

  wb_rr_pick #(.N(NM), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Everything slave-bound is gated by the registered grant, so reset clears it asynchronously.
  assign owner_cyc = |(M_CYC_I & GNT_O);
  assign S_CYC_O   = owner_cyc;
  assign S_STB_O   = |(M_STB_I & M_CYC_I & GNT_O);
  assign S_WE_O    = |(M_WE_I & GNT_O);
  assign M_ACK_O   = GNT_O & {NM{S_ACK_I}};
  assign M_DAT_O   = S_DAT_I;

  always_comb begin
    S_ADR_O   = '0;
    S_DAT_O   = '0;
    S_SEL_O   = '0;
    owner_idx = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (GNT_O[i]) begin
        S_ADR_O   = M_ADR_I[i*AW +: AW];
        S_DAT_O   = M_DAT_I[i*DW +: DW];
        S_SEL_O   = M_SEL_I[i*SW +: SW];
        owner_idx = PW'(i);
      end
    end
  end

  assign next_ptr    = (owner_idx == PW'(NM - 1)) ? '0 : owner_idx + PW'(1);
  assign release_bus = !owner_cyc || to_hit;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT < 256) ? 8 : 16;

  logic [CW-1:0] to_cnt;
  logic [NM-1:0] to_err;
  logic [NM-1:0] blocked;

  assign to_hit  = (state == WB_ARB_OWNED) && S_STB_O && !S_ACK_I && !S_ERR_I &&
                   (to_cnt == CW'(TIMEOUT - 1));
  // A timed-out master stays masked until it drops CYC.
  assign req     = M_CYC_I & ~blocked;
  assign M_ERR_O = (GNT_O & {NM{S_ERR_I}}) | to_err;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      to_cnt  <= '0;
      to_err  <= '0;
      blocked <= '0;
    end else begin
      to_err  <= to_hit ? GNT_O : '0;
      blocked <= (blocked | (to_hit ? GNT_O : '0)) & M_CYC_I;
      if (state != WB_ARB_OWNED || S_ACK_I || S_ERR_I) to_cnt <= '0;
      else if (S_STB_O)                                to_cnt <= to_cnt + CW'(1);
    end
  end
`else
  assign to_hit  = 1'b0;
  assign req     = M_CYC_I;
  assign M_ERR_O = GNT_O & {NM{S_ERR_I}};
`endif

  // Grant FSM: IDLE picks a winner, OWNED holds until the owner drops CYC.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state  <= WB_ARB_IDLE;
      GNT_O  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        WB_ARB_IDLE: begin
          if (pick_valid) begin
            GNT_O <= pick_gnt;
            state <= WB_ARB_OWNED;
          end
        end
        WB_ARB_OWNED: begin
          if (release_bus) begin
            GNT_O  <= '0;
            rr_ptr <= next_ptr;
            state  <= WB_ARB_IDLE;
          end
        end
        default: begin
          GNT_O <= '0;
          state <= WB_ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (NM=2): vector table, hand sequences, random vs. reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0] cyc, stb, we;
  logic [AW-1:0] madr [NM];
  logic [DW-1:0] mdat [NM];
  logic [SW-1:0] msel [NM];
  logic          sack, serr;
  logic [DW-1:0] sdat;

  logic [NM-1:0] m_ack, m_err, gnt;
  logic [DW-1:0] m_dat_o;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat;
  logic [SW-1:0] s_sel;

  int n_pass = 0;
  int n_total = 0;

  int owner;
  int ptr;

  always #5 clk = ~clk;

  wb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW)) dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .M_CYC_I (cyc),
    .M_STB_I (stb),
    .M_WE_I  (we),
    .M_ADR_I ({madr[1], madr[0]}),
    .M_DAT_I ({mdat[1], mdat[0]}),
    .M_SEL_I ({msel[1], msel[0]}),
    .M_ACK_O (m_ack),
    .M_ERR_O (m_err),
    .M_DAT_O (m_dat_o),
    .S_CYC_O (s_cyc),
    .S_STB_O (s_stb),
    .S_WE_O  (s_we),
    .S_ADR_O (s_adr),
    .S_DAT_O (s_dat),
    .S_SEL_O (s_sel),
    .S_DAT_I (sdat),
    .S_ACK_I (sack),
    .S_ERR_I (serr),
    .GNT_O   (gnt)
  );

  typedef struct {
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic       err;
    logic [1:0] gnt;
    logic [1:0] mack;
    logic [1:0] merr;
    logic       scyc;
    logic       sstb;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; we = '0; sack = 1'b0; serr = 1'b0;
    for (int i = 0; i < NM; i++) begin
      madr[i] = '0; mdat[i] = '0; msel[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    owner = -1;
    ptr   = 0;
  endtask

  // Reference: one owner (or none) and a pointer; grants at edges from the request vector.
  task automatic model_edge();
    bit found;
    found = 1'b0;
    if (owner < 0) begin
      for (int k = 0; k < NM; k++) begin
        int c;
        c = (ptr + k) % NM;
        if (!found && cyc[c]) begin
          owner = c;
          found = 1'b1;
        end
      end
    end else if (!cyc[owner]) begin
      ptr   = (owner + 1) % NM;
      owner = -1;
    end
  endtask

  task automatic model_check();
    logic [1:0]    eg, emack, emerr;
    logic          escyc, esstb, ewe;
    logic [AW-1:0] eadr;
    logic [DW-1:0] edat;
    logic [SW-1:0] esel;
    eg = '0; emack = '0; emerr = '0;
    escyc = 1'b0; esstb = 1'b0; ewe = 1'b0;
    eadr = '0; edat = '0; esel = '0;
    if (owner >= 0) begin
      eg[owner]    = 1'b1;
      escyc        = cyc[owner];
      esstb        = cyc[owner] & stb[owner];
      ewe          = we[owner];
      eadr         = madr[owner];
      edat         = mdat[owner];
      esel         = msel[owner];
      emack[owner] = sack;
      emerr[owner] = serr;
    end
    check("rnd_gnt",   64'(gnt),     64'(eg));
    check("rnd_scyc",  64'(s_cyc),   64'(escyc));
    check("rnd_sstb",  64'(s_stb),   64'(esstb));
    check("rnd_swe",   64'(s_we),    64'(ewe));
    check("rnd_sadr",  64'(s_adr),   64'(eadr));
    check("rnd_sdat",  64'(s_dat),   64'(edat));
    check("rnd_ssel",  64'(s_sel),   64'(esel));
    check("rnd_mack",  64'(m_ack),   64'(emack));
    check("rnd_merr",  64'(m_err),   64'(emerr));
    check("rnd_mdat",  64'(m_dat_o), 64'(sdat));
  endtask

  initial begin
    // cyc, stb, ack, err | gnt, mack, merr, scyc, sstb
    tbl[0]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1};
    tbl[2]  = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 2'b10, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1};
    tbl[5]  = '{2'b01, 2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{2'b11, 2'b01, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1};
    tbl[8]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{2'b01, 2'b01, 1'b0, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1};

    // Reset state
    clear_inputs();
    sdat = 32'hA5A5_5A5A;
    rst  = 1'b1;
    #2;
    check("rst_gnt",  64'(gnt),     64'(0));
    check("rst_scyc", 64'(s_cyc),   64'(0));
    check("rst_mack", 64'(m_ack),   64'(0));
    check("rst_mdat", 64'(m_dat_o), 64'(32'hA5A5_5A5A));
    next_cycle();
    rst = 1'b0;

    // Vector table: round-robin, release, ack-with-drop, stray termination, absent requester
    for (int r = 0; r < 12; r++) begin
      cyc = tbl[r].cyc; stb = tbl[r].stb; sack = tbl[r].ack; serr = tbl[r].err;
      #2;
      check($sformatf("tbl%0d_gnt", r),  64'(gnt),   64'(tbl[r].gnt));
      check($sformatf("tbl%0d_mack", r), 64'(m_ack), 64'(tbl[r].mack));
      check($sformatf("tbl%0d_merr", r), 64'(m_err), 64'(tbl[r].merr));
      check($sformatf("tbl%0d_scyc", r), 64'(s_cyc), 64'(tbl[r].scyc));
      check($sformatf("tbl%0d_sstb", r), 64'(s_stb), 64'(tbl[r].sstb));
      next_cycle();
    end

    // Single request: grant one cycle after CYC, address routed, ack to owner only
    do_reset();
    madr[0] = 32'h3C; madr[1] = 32'h55;
    cyc = 2'b01;
    #2;
    check("single_gnt_n", 64'(gnt), 64'(0));
    next_cycle();
    #1;
    check("single_gnt",  64'(gnt),   64'(2'b01));
    check("single_scyc", 64'(s_cyc), 64'(1));
    check("single_sadr", 64'(s_adr), 64'(32'h3C));
    stb = 2'b01; sack = 1'b1;
    #1;
    check("single_mack", 64'(m_ack), 64'(2'b01));

    // No preemption: master 1 requests while master 0 runs three beats
    cyc = 2'b11;
    for (int b = 0; b < 3; b++) begin
      next_cycle();
      #1;
      check($sformatf("nopre_gnt%0d", b), 64'(gnt), 64'(2'b01));
    end
    cyc = 2'b10; stb = 2'b00; sack = 1'b0;
    next_cycle();
    #1;
    check("nopre_rel_gnt",  64'(gnt),   64'(0));
    check("nopre_rel_scyc", 64'(s_cyc), 64'(0));
    next_cycle();
    #1;
    check("nopre_m1_gnt", 64'(gnt), 64'(2'b10));

    // Reset mid-transfer releases without a clock edge
    cyc = 2'b11; stb = 2'b10;
    #1;
    check("midrst_pre_scyc", 64'(s_cyc), 64'(1));
    check("midrst_pre_sstb", 64'(s_stb), 64'(1));
    rst = 1'b1;
    #1;
    check("midrst_gnt",  64'(gnt),   64'(0));
    check("midrst_scyc", 64'(s_cyc), 64'(0));
    check("midrst_sstb", 64'(s_stb), 64'(0));
    next_cycle();
    rst = 1'b0;
    #1;
    check("midrst_idle_gnt", 64'(gnt), 64'(0));
    next_cycle();
    #1;
    check("midrst_first_gnt", 64'(gnt), 64'(2'b01));

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(3) == 0) cyc[i] = ~cyc[i];
        stb[i]  = 1'($urandom_range(1));
        we[i]   = 1'($urandom_range(1));
        madr[i] = $urandom;
        mdat[i] = $urandom;
        msel[i] = 4'($urandom);
      end
      sack = ($urandom_range(2) == 0);
      serr = ($urandom_range(4) == 0);
      sdat = $urandom;
      #2;
      model_check();
      model_edge();
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
